// File: rtl/zrb_fifo_wr_arbiter_if.sv
// Write-port bundle shared by the requesters, the arbiter and the FIFO write side.
// master: requesters plus FIFO status; slave: the arbiter.
interface zrb_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic [IDX_WIDTH-1:0]          owner;
  logic                          busy;

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_wr_en, fifo_data, owner, busy
  );

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_wr_en, fifo_data, owner, busy
  );
endinterface

// File: rtl/zrb_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the zrb_fifo write port among NUM_REQ requesters.
// Grants bursts of up to MAX_BURST words, gates every write with fifo_full and
// produces ack/wr_en/data combinationally so a request can be written the same cycle.
//
// state | meaning
// IDLE  | scanning requests from r_ptr with wrap; first word of a grant goes out here
// BURST | r_owner holds the port; r_cnt words written so far in this burst
module zrb_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic                  wr_clk,
  input logic                  reset,
  zrb_fifo_wr_arbiter_if.slave bus
);

  // Request vector padded to a power of two so an IDX_WIDTH index never overruns it.
  localparam int PAD = 2 ** IDX_WIDTH;
  localparam int PW  = IDX_WIDTH + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                r_state, nx_state;
  logic [IDX_WIDTH-1:0]  r_owner, nx_owner;
  logic [IDX_WIDTH-1:0]  r_ptr, nx_ptr;
  logic [7:0]            r_cnt, nx_cnt;
  logic [IDX_WIDTH-1:0]  scan_sel, sel;
  logic                  scan_hit;
  logic [PAD-1:0]        req_pad;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx);
    if (idx == IDX_WIDTH'(NUM_REQ - 1)) return '0;
    return idx + IDX_WIDTH'(1);
  endfunction

  assign req_pad = PAD'(bus.req);

  // Find the first pending requester starting at r_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    logic [PW-1:0] pos;
    pos      = '0;
    scan_hit = 1'b0;
    scan_sel = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, r_ptr} + PW'(k);
      if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
      if (!scan_hit && req_pad[pos[IDX_WIDTH-1:0]]) begin
        scan_hit = 1'b1;
        scan_sel = pos[IDX_WIDTH-1:0];
      end
    end
  end

  // A held burst pins the selection; other requesters are ignored until it ends.
  assign sel  = (r_state == BURST) ? r_owner : scan_sel;
  assign xfer = req_pad[sel] & ~bus.fifo_full & ~reset;

  // Word mux for the selected requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_WIDTH'(i)) sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Write-port outputs; everything is forced to zero while reset is high.
  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_WIDTH'(i)) bus.ack[i] = xfer;
    end
    bus.fifo_wr_en = xfer;
    bus.fifo_data  = reset ? '0 : sel_data;
    bus.owner      = reset ? '0 : sel;
    bus.busy       = (r_state == BURST) & ~reset;
  end

  // Next-state logic: start, extend, stall or release a burst.
  always_comb begin
    nx_state = r_state;
    nx_owner = r_owner;
    nx_cnt   = r_cnt;
    nx_ptr   = r_ptr;
    case (r_state)
      IDLE: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            nx_ptr = next_idx(sel);
          end else begin
            nx_state = BURST;
            nx_owner = sel;
            nx_cnt   = 8'd1;
          end
        end
      end
      BURST: begin
        if (!req_pad[r_owner]) begin
          // Owner dropped its request: give up the port, costing one idle cycle.
          nx_state = IDLE;
          nx_ptr   = next_idx(r_owner);
        end else if (xfer) begin
          nx_cnt = r_cnt + 8'd1;
          if (nx_cnt == 8'(MAX_BURST)) begin
            nx_state = IDLE;
            nx_ptr   = next_idx(r_owner);
          end
        end
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= nx_state;
      r_owner <= nx_owner;
      r_cnt   <= nx_cnt;
      r_ptr   <= nx_ptr;
    end
  end

endmodule

// File: tb/tb_zrb_fifo_wr_arbiter.sv
// Bench for zrb_fifo_wr_arbiter: two instances (MAX_BURST 4 and 2) checked every
// cycle against a burst/pointer model, plus literal grant sequences per scenario.
module tb_zrb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;

  logic wr_clk = 1'b0;
  logic reset  = 1'b1;

  always #5 wr_clk = ~wr_clk;

  zrb_fifo_wr_arbiter_if #(.NUM_REQ(N), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) if_a ();
  zrb_fifo_wr_arbiter_if #(.NUM_REQ(N), .IDX_WIDTH(IW), .DATA_WIDTH(DW)) if_b ();

  zrb_fifo_wr_arbiter #(.NUM_REQ(N), .IDX_WIDTH(IW), .DATA_WIDTH(DW), .MAX_BURST(4)) u_a (
    .wr_clk (wr_clk),
    .reset  (reset),
    .bus    (if_a)
  );

  zrb_fifo_wr_arbiter #(.NUM_REQ(N), .IDX_WIDTH(IW), .DATA_WIDTH(DW), .MAX_BURST(2)) u_b (
    .wr_clk (wr_clk),
    .reset  (reset),
    .bus    (if_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: who holds a burst (-1 = nobody), words in it, and where the next scan starts.
  int mb[2]     = '{4, 2};
  int m_hold[2] = '{-1, -1};
  int m_cnt[2]  = '{0, 0};
  int m_ptr[2]  = '{0, 0};

  // Per-cycle record of what each DUT actually did (requester index written, or -1).
  int log_ack[2][$];
  int log_busy[2][$];

  // Literal expectation hand-off from the stimulus process.
  int lit_req   = 0;
  int lit_done  = 0;
  int lit_dut   = 0;
  int lit_start = 0;
  int lit_exp[$];
  int lit_busy[$];

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  always @(negedge wr_clk) begin
    logic [N-1:0]    rq, a_ack, e_ack;
    logic [N*DW-1:0] rd;
    logic            fl, a_wr, a_busy, e_x, e_busy;
    logic [DW-1:0]   a_data;
    logic [IW-1:0]   a_own;
    int              e_sel, a_idx;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        rq = if_a.req; rd = if_a.req_data; fl = if_a.fifo_full;
        a_ack = if_a.ack; a_wr = if_a.fifo_wr_en; a_busy = if_a.busy;
        a_data = if_a.fifo_data; a_own = if_a.owner;
      end else begin
        rq = if_b.req; rd = if_b.req_data; fl = if_b.fifo_full;
        a_ack = if_b.ack; a_wr = if_b.fifo_wr_en; a_busy = if_b.busy;
        a_data = if_b.fifo_data; a_own = if_b.owner;
      end
      a_idx = -1;
      for (int i = 0; i < N; i++) if (a_ack[i]) a_idx = i;
      log_ack[d].push_back(a_wr ? a_idx : -1);
      log_busy[d].push_back(int'(a_busy));

      if (reset) begin
        chk("ack_in_reset", d, int'(a_ack), 0);
        chk("wr_en_in_reset", d, int'(a_wr), 0);
        chk("busy_in_reset", d, int'(a_busy), 0);
        chk("owner_in_reset", d, int'(a_own), 0);
        chk("data_in_reset", d, int'(a_data), 0);
        m_hold[d] = -1;
        m_cnt[d]  = 0;
        m_ptr[d]  = 0;
      end else begin
        e_busy = (m_hold[d] >= 0);
        if (e_busy) begin
          e_sel = m_hold[d];
        end else begin
          e_sel = m_ptr[d];
          for (int k = N - 1; k >= 0; k--) if (rq[(m_ptr[d] + k) % N]) e_sel = (m_ptr[d] + k) % N;
        end
        e_x   = rq[e_sel] && !fl;
        e_ack = e_x ? (N'(1) << e_sel) : '0;
        chk("ack", d, int'(a_ack), int'(e_ack));
        chk("wr_en", d, int'(a_wr), int'(e_x));
        chk("busy", d, int'(a_busy), int'(e_busy));
        chk("owner", d, int'(a_own), e_sel);
        if (e_x) chk("data", d, int'(a_data), int'(rd[e_sel*DW +: DW]));

        if (!e_busy) begin
          if (e_x) begin
            if (mb[d] == 1) m_ptr[d] = (e_sel + 1) % N;
            else begin
              m_hold[d] = e_sel;
              m_cnt[d]  = 1;
            end
          end
        end else if (!rq[e_sel]) begin
          m_hold[d] = -1;
          m_ptr[d]  = (e_sel + 1) % N;
        end else if (e_x) begin
          m_cnt[d]++;
          if (m_cnt[d] == mb[d]) begin
            m_hold[d] = -1;
            m_ptr[d]  = (e_sel + 1) % N;
          end
        end
      end
    end

    if (lit_req != lit_done) begin
      for (int i = 0; i < lit_exp.size(); i++)
        chk("grant_seq", lit_dut, log_ack[lit_dut][lit_start + i], lit_exp[i]);
      for (int i = 0; i < lit_busy.size(); i++)
        chk("busy_seq", lit_dut, log_busy[lit_dut][lit_start + i], lit_busy[i]);
      lit_done = lit_done + 1;
    end
    cyc = cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_a.req = '0; if_a.fifo_full = 1'b0;
    if_b.req = '0; if_b.fifo_full = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic lit(input int d, input int start, input int e_ack[$], input int e_busy[$]);
    lit_dut   = d;
    lit_start = start;
    lit_exp   = e_ack;
    lit_busy  = e_busy;
    lit_req   = lit_req + 1;
    step(2);
  endtask

  initial begin
    int start;
    if_a.req = '0; if_a.req_data = '0; if_a.fifo_full = 1'b0;
    if_b.req = '0; if_b.req_data = '0; if_b.fifo_full = 1'b0;
    step(3);

    // Idle after reset: nothing written, owner parked at 0.
    do_reset();
    start = cyc;
    step(10);
    lit(0, start, '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    // Lone requester 2 streams 6 words with MAX_BURST=4, then the pointer sits at 3.
    do_reset();
    start = cyc;
    for (int k = 0; k < 6; k++) begin
      if_a.req = 4'b0100;
      if_a.req_data = {8'h33, 8'h20 + 8'(k), 8'h11, 8'h00};
      step(1);
    end
    if_a.req = '0;
    step(2);
    if_a.req = 4'b1111;
    step(1);
    if_a.req = '0;
    lit(0, start, '{2, 2, 2, 2, 2, 2, -1, -1, 3}, '{0, 1, 1, 1, 0, 1, 1, 0, 0});

    // All four requesting with MAX_BURST=2: pairs in round-robin order, no gaps.
    do_reset();
    start = cyc;
    if_b.req_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    if_b.req = 4'b1111;
    step(10);
    if_b.req = '0;
    lit(1, start, '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0}, '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1});

    // Requester 1 stalled by fifo_full for 3 cycles after its first word.
    do_reset();
    start = cyc;
    if_a.req_data = {8'h00, 8'h00, 8'h51, 8'h00};
    if_a.req = 4'b0010;
    step(1);
    if_a.req_data = {8'h00, 8'h00, 8'h52, 8'h00};
    if_a.fifo_full = 1'b1;
    step(3);
    if_a.fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if_a.req_data = {8'h00, 8'h00, 8'h53 + 8'(k), 8'h00};
    end
    if_a.req = '0;
    step(1);
    lit(0, start, '{1, -1, -1, -1, 1, 1, 1, -1}, '{0, 1, 1, 1, 1, 1, 1, 0});

    // Requester 1 drops after one word: one bubble, then 3 wins over 0.
    do_reset();
    start = cyc;
    if_a.req_data = {8'h3A, 8'h00, 8'h1A, 8'h0A};
    if_a.req = 4'b1010;
    step(1);
    if_a.req = 4'b1001;
    step(6);
    if_a.req = '0;
    step(1);
    lit(0, start, '{1, -1, 3, 3, 3, 3, 0, -1}, '{0, 1, 0, 1, 1, 1, 0, 1});

    // Reset lands on requester 2's second word; arbitration restarts at 0.
    do_reset();
    start = cyc;
    if_a.req_data = {8'h00, 8'hC2, 8'h00, 8'hC0};
    if_a.req = 4'b0001;
    step(4);
    if_a.req = 4'b0101;
    step(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(5);
    if_a.req = '0;
    lit(0, start, '{0, 0, 0, 0, 2, -1, -1, 0, 0, 0, 0, 2}, '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0});

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 200000", $time);
    $fatal(1);
  end

endmodule
